// File: rtl/time_report_tx.sv
// Streams a snapshot of a 24-bit {hour,min,sec,hundredths} time as "HH:MM:SS.CC"
// (plus optional CR LF) into a byte-wide UART transmitter, one status line per request.
module time_report_tx #(
    parameter int CRLF_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [23:0] i_time,
    input  logic        i_tx_busy,
    output logic        o_tx_start,
    output logic [7:0]  o_tx_data,
    output logic        o_busy,
    output logic        o_done
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_t;

    localparam logic [3:0] LAST = (CRLF_EN != 0) ? 4'd12 : 4'd10;

    state_t      state;
    logic [3:0]  idx;
    logic        pending;
    logic [23:0] snap;
    logic [7:0]  cur_byte;

    // Fields above 99 (only hundredths can get there) print as 99.
    function automatic logic [7:0] digit(input logic [6:0] v, input logic tens);
        logic [6:0] c;
        logic [6:0] d;
        c = (v > 7'd99) ? 7'd99 : v;
        d = tens ? (c / 7'd10) : (c % 7'd10);
        return 8'h30 + {1'b0, d};
    endfunction

    always_comb begin
        cur_byte = 8'h00;
        case (idx)
            4'd0:    cur_byte = digit({2'b00, snap[23:19]}, 1'b1);
            4'd1:    cur_byte = digit({2'b00, snap[23:19]}, 1'b0);
            4'd2:    cur_byte = 8'h3A;
            4'd3:    cur_byte = digit({1'b0, snap[18:13]}, 1'b1);
            4'd4:    cur_byte = digit({1'b0, snap[18:13]}, 1'b0);
            4'd5:    cur_byte = 8'h3A;
            4'd6:    cur_byte = digit({1'b0, snap[12:7]}, 1'b1);
            4'd7:    cur_byte = digit({1'b0, snap[12:7]}, 1'b0);
            4'd8:    cur_byte = 8'h2E;
            4'd9:    cur_byte = digit(snap[6:0], 1'b1);
            4'd10:   cur_byte = digit(snap[6:0], 1'b0);
            4'd11:   cur_byte = 8'h0D;
            4'd12:   cur_byte = 8'h0A;
            default: cur_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= 4'd0;
            pending    <= 1'b0;
            snap       <= 24'd0;
            o_tx_start <= 1'b0;
            o_tx_data  <= 8'h00;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            o_done     <= 1'b0;
            if (state != IDLE && i_req)
                pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (i_req) begin
                        snap   <= i_time;
                        idx    <= 4'd0;
                        o_busy <= 1'b1;
                        state  <= SEND;
                    end
                end
                SEND: begin
                    if (!i_tx_busy) begin
                        o_tx_start <= 1'b1;
                        o_tx_data  <= cur_byte;
                        state      <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (i_tx_busy)
                        state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!i_tx_busy) begin
                        if (idx == LAST) begin
                            o_done <= 1'b1;
                            // A request landing on this very edge is treated as pending.
                            if (pending || i_req) begin
                                pending <= 1'b0;
                                snap    <= i_time;
                                idx     <= 4'd0;
                                state   <= SEND;
                            end else begin
                                o_busy <= 1'b0;
                                state  <= IDLE;
                            end
                        end else begin
                            idx   <= idx + 4'd1;
                            state <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_time_report_tx.sv
// Bench for time_report_tx: UART TX models, a $sformatf-based line model and
// directed plus randomized frames on a CRLF and a no-CRLF instance.
module tb_time_report_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        req0 = 1'b0;
    logic [23:0] tim = 24'd0;
    logic        tx_busy, tx_busy0;
    logic        tx_start, tx_start0;
    logic [7:0]  tx_data, tx_data0;
    logic        busy, busy0, done, done0;

    logic force_busy = 1'b0;
    int   ack_dly = 2;
    int   hold = 10;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    time_report_tx #(.CRLF_EN(1)) dut (
        .clk(clk), .rst(rst), .i_req(req), .i_time(tim), .i_tx_busy(tx_busy),
        .o_tx_start(tx_start), .o_tx_data(tx_data), .o_busy(busy), .o_done(done)
    );

    time_report_tx #(.CRLF_EN(0)) dut0 (
        .clk(clk), .rst(rst), .i_req(req0), .i_time(tim), .i_tx_busy(tx_busy0),
        .o_tx_start(tx_start0), .o_tx_data(tx_data0), .o_busy(busy0), .o_done(done0)
    );

    // UART model: busy rises ack_dly cycles after a start and stays up hold cycles.
    logic mbusy = 1'b0;
    int   u_ack = 0;
    int   u_hold = 0;
    assign tx_busy = mbusy | force_busy;
    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            u_ack <= ack_dly;
        end else if (u_ack != 0) begin
            u_ack <= u_ack - 1;
            if (u_ack == 1) begin
                mbusy  <= 1'b1;
                u_hold <= hold;
            end
        end else if (mbusy) begin
            u_hold <= u_hold - 1;
            if (u_hold == 1) mbusy <= 1'b0;
        end
    end

    logic mbusy0 = 1'b0;
    int   u_ack0 = 0;
    int   u_hold0 = 0;
    assign tx_busy0 = mbusy0;
    always @(negedge clk) begin
        if (tx_start0 === 1'b1) begin
            u_ack0 <= 1;
        end else if (u_ack0 != 0) begin
            u_ack0 <= 0;
            mbusy0 <= 1'b1;
            u_hold0 <= 3;
        end else if (mbusy0) begin
            u_hold0 <= u_hold0 - 1;
            if (u_hold0 == 1) mbusy0 <= 1'b0;
        end
    end

    // Monitors: capture bytes, count done pulses, busy falls and protocol violations.
    logic [7:0] got[$];
    logic [7:0] got0[$];
    int   done_cnt = 0, done0_cnt = 0, busy_falls = 0, proto_err = 0, proto_err0 = 0;
    logic done_busy = 1'b0, start_prev = 1'b0, start0_prev = 1'b0, busy_prev = 1'b0;
    logic busy_q = 1'b0, busy0_q = 1'b0;

    always @(posedge clk) begin
        busy_q  <= tx_busy;
        busy0_q <= tx_busy0;
    end

    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            got.push_back(tx_data);
            if (start_prev || busy_q) proto_err <= proto_err + 1;
        end
        if (done === 1'b1) begin
            done_cnt  <= done_cnt + 1;
            done_busy <= busy;
        end
        if (busy_prev === 1'b1 && busy === 1'b0) busy_falls <= busy_falls + 1;
        start_prev <= tx_start;
        busy_prev  <= busy;
    end

    always @(negedge clk) begin
        if (tx_start0 === 1'b1) begin
            got0.push_back(tx_data0);
            if (start0_prev || busy0_q) proto_err0 <= proto_err0 + 1;
        end
        if (done0 === 1'b1) done0_cnt <= done0_cnt + 1;
        start0_prev <= tx_start0;
    end

    function automatic int cl(input int v);
        return (v > 99) ? 99 : v;
    endfunction

    function automatic string frame_str(input logic [23:0] t, input bit crlf);
        string s;
        s = $sformatf("%02d:%02d:%02d.%02d", cl(int'(t[23:19])), cl(int'(t[18:13])),
                      cl(int'(t[12:7])), cl(int'(t[6:0])));
        if (crlf) s = {s, "\r\n"};
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_frame(input string tag, input string exp, input int base, input bit which);
        int n;
        n = which ? (got0.size() - base) : (got.size() - base);
        chk({tag, " len"}, 32'(n), 32'(exp.len()));
        for (int i = 0; i < exp.len() && i < n; i++)
            chk($sformatf("%s byte%0d", tag, i),
                {24'd0, which ? got0[base + i] : got[base + i]}, {24'd0, 8'(exp[i])});
    endtask

    task automatic wait_got(input int target, input string tag);
        int n = 0;
        while (got.size() < target && n < 2000) begin @(negedge clk); n++; end
        chk({tag, " byte wait"}, 32'(got.size() >= target), 32'd1);
    endtask

    task automatic wait_done(input int target, input int target0, input string tag);
        int n = 0;
        while ((done_cnt < target || done0_cnt < target0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " done wait"}, 32'(done_cnt >= target && done0_cnt >= target0), 32'd1);
    endtask

    task automatic pulse(input bit r1, input bit r0);
        @(posedge clk); #2;
        req  = r1;
        req0 = r0;
        @(posedge clk); #2;
        req  = 1'b0;
        req0 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, base0, dbase, dbase0, fbase;
        logic [23:0] t1, t2;
        bit found;
        logic [7:0] first;

        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst start", 32'(tx_start), 32'd0);
        chk("rst data", {24'd0, tx_data}, 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst busy0", 32'(busy0), 32'd0);
        @(posedge clk); #2 rst = 1'b1;

        // Normal frame with exact request-to-first-byte latency.
        tim = {5'd12, 6'd34, 6'd56, 7'd78};
        ack_dly = 2; hold = 10;
        base = got.size(); dbase = done_cnt;
        @(posedge clk); #2 req = 1'b1;
        @(negedge clk);
        chk("pre busy", 32'(busy), 32'd0);
        @(posedge clk); #2 req = 1'b0;
        @(negedge clk);
        chk("lat busy", 32'(busy), 32'd1);
        chk("lat start early", 32'(tx_start), 32'd0);
        @(negedge clk);
        chk("lat start", 32'(tx_start), 32'd1);
        chk("lat data", {24'd0, tx_data}, 32'h31);
        wait_done(dbase + 1, done0_cnt, "normal");
        repeat (5) @(negedge clk);
        check_frame("normal", "12:34:56.78\r\n", base, 1'b0);
        chk("normal dones", 32'(done_cnt), 32'(dbase + 1));
        chk("normal busy end", 32'(busy), 32'd0);
        chk("normal busy at done", 32'(done_busy), 32'd0);

        // Clamp and zeros on both instances.
        tim = {5'd0, 6'd0, 6'd5, 7'd120};
        base = got.size(); base0 = got0.size(); dbase = done_cnt; dbase0 = done0_cnt;
        pulse(1'b1, 1'b1);
        wait_done(dbase + 1, dbase0 + 1, "clamp");
        repeat (5) @(negedge clk);
        check_frame("clamp", "00:00:05.99\r\n", base, 1'b0);
        check_frame("clamp nocrlf", "00:00:05.99", base0, 1'b1);

        // Randomized times and UART handshake timing.
        for (int k = 0; k < 4; k++) begin
            tim = 24'($urandom);
            ack_dly = int'($urandom_range(1, 3));
            hold = int'($urandom_range(1, 12));
            base = got.size(); base0 = got0.size(); dbase = done_cnt; dbase0 = done0_cnt;
            pulse(1'b1, 1'b1);
            wait_done(dbase + 1, dbase0 + 1, "rand");
            repeat (5) @(negedge clk);
            check_frame($sformatf("rand%0d", k), frame_str(tim, 1'b1), base, 1'b0);
            check_frame($sformatf("rand%0d nocrlf", k), frame_str(tim, 1'b0), base0, 1'b1);
        end

        // Snapshot stability plus collapsed pending requests.
        ack_dly = 2; hold = 10;
        t1 = 24'($urandom);
        t2 = {5'd1, 6'd2, 6'd3, 7'd4};
        tim = t1;
        base = got.size(); dbase = done_cnt; fbase = busy_falls;
        pulse(1'b1, 1'b0);
        wait_got(base + 5, "pend");
        tim = t2;
        pulse(1'b1, 1'b0);
        repeat (3) @(posedge clk);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        wait_done(dbase + 2, done0_cnt, "pend");
        repeat (60) @(negedge clk);
        check_frame("pend", {frame_str(t1, 1'b1), "01:02:03.04\r\n"}, base, 1'b0);
        chk("pend dones", 32'(done_cnt), 32'(dbase + 2));
        chk("pend busy falls", 32'(busy_falls), 32'(fbase + 1));
        chk("pend busy end", 32'(busy), 32'd0);

        // UART busy when the request arrives.
        tim = 24'($urandom);
        base = got.size(); dbase = done_cnt;
        @(posedge clk); #2 force_busy = 1'b1;
        pulse(1'b1, 1'b0);
        repeat (48) @(negedge clk);
        chk("hold busy", 32'(busy), 32'd1);
        chk("hold no start", 32'(got.size()), 32'(base));
        @(posedge clk); #2 force_busy = 1'b0;
        found = 1'b0;
        first = 8'h00;
        for (int k = 0; k < 3 && !found; k++) begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                found = 1'b1;
                first = tx_data;
            end
        end
        chk("hold release start", 32'(found), 32'd1);
        wait_done(dbase + 1, done0_cnt, "hold");
        repeat (5) @(negedge clk);
        chk("hold first byte", {24'd0, first}, {24'd0, 8'(frame_str(tim, 1'b1).getc(0))});
        check_frame("hold", frame_str(tim, 1'b1), base, 1'b0);

        // Reset during byte 6, then a clean frame.
        tim = 24'($urandom);
        base = got.size(); dbase = done_cnt;
        pulse(1'b1, 1'b0);
        wait_got(base + 7, "reset");
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid rst start", 32'(tx_start), 32'd0);
        chk("mid rst data", {24'd0, tx_data}, 32'd0);
        chk("mid rst busy", 32'(busy), 32'd0);
        chk("mid rst done", 32'(done), 32'd0);
        @(posedge clk); #2 rst = 1'b1;
        repeat (40) @(negedge clk);
        chk("mid rst no starts", 32'(got.size()), 32'(base + 7));
        chk("mid rst no done", 32'(done_cnt), 32'(dbase));
        base = got.size(); dbase = done_cnt;
        pulse(1'b1, 1'b0);
        wait_done(dbase + 1, done0_cnt, "post rst");
        repeat (5) @(negedge clk);
        check_frame("post rst", frame_str(tim, 1'b1), base, 1'b0);

        // Fastest handshake: busy one cycle after start, held one cycle.
        ack_dly = 1; hold = 1;
        tim = 24'($urandom);
        base = got.size(); dbase = done_cnt;
        pulse(1'b1, 1'b0);
        wait_done(dbase + 1, done0_cnt, "b2b");
        repeat (5) @(negedge clk);
        check_frame("b2b", frame_str(tim, 1'b1), base, 1'b0);

        chk("protocol", 32'(proto_err), 32'd0);
        chk("protocol nocrlf", 32'(proto_err0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
